// File: rtl/band_note_enumerator_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// band_note_enumerator_pkg : shared band/note widths and enumerator state type
// Rev 1.0
// ---------------------------------------------------------------------------
package band_note_enumerator_pkg;

  localparam int DEF_NUM_BANDS      = 22;
  localparam int DEF_MIDI_NOTES     = 128;
  localparam int DEF_NOTES_PER_BAND = 6;

  // Port widths never collapse to zero, even for degenerate single-entry spaces.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int BAND_W = clog2_min1(DEF_NUM_BANDS);
  localparam int NOTE_W = clog2_min1(DEF_MIDI_NOTES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } bne_state_e;

endpackage
`default_nettype wire

// File: rtl/band_note_enumerator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// band_note_enumerator : serially emits every MIDI note belonging to a band
// Rev 1.0
// ---------------------------------------------------------------------------
module band_note_enumerator
  import band_note_enumerator_pkg::*;
#(
  parameter int NUM_BANDS      = DEF_NUM_BANDS,
  parameter int MIDI_NOTES     = DEF_MIDI_NOTES,
  parameter int NOTES_PER_BAND = DEF_NOTES_PER_BAND
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [clog2_min1(NUM_BANDS)-1:0] req_band,
  output logic                             note_valid,
  input  logic                             note_ready,
  output logic [clog2_min1(MIDI_NOTES)-1:0] note,
  output logic                             note_last,
  output logic                             req_err
);

  localparam int NW = clog2_min1(MIDI_NOTES);
  localparam int AW = $clog2(NUM_BANDS*NOTES_PER_BAND + MIDI_NOTES) + 1;
  localparam logic [AW-1:0] TOP_NOTE_A = AW'(MIDI_NOTES - 1);

  bne_state_e    state_q;
  logic [NW-1:0] note_q;
  logic [NW-1:0] end_q;
  logic          valid_q;
  logic          last_q;
  logic          err_q;

  logic [AW-1:0] band_a;
  logic [AW-1:0] start_a;
  logic [AW-1:0] span_end_a;
  logic [AW-1:0] end_a;
  logic          reject;

  // Wide enough that out-of-range bands cannot wrap back into the note space.
  always_comb begin
    band_a     = AW'(req_band);
    start_a    = band_a * AW'(NOTES_PER_BAND);
    span_end_a = (band_a == AW'(NUM_BANDS - 1)) ? TOP_NOTE_A
                                                 : start_a + AW'(NOTES_PER_BAND - 1);
    end_a      = (span_end_a > TOP_NOTE_A) ? TOP_NOTE_A : span_end_a;
    reject     = (band_a >= AW'(NUM_BANDS)) || (start_a >= AW'(MIDI_NOTES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      note_q  <= '0;
      end_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              state_q <= ST_EMIT;
              note_q  <= start_a[NW-1:0];
              end_q   <= end_a[NW-1:0];
              valid_q <= 1'b1;
              last_q  <= (start_a == end_a);
            end
          end
        end
        ST_EMIT: begin
          if (note_ready) begin
            if (last_q) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              note_q  <= '0;
            end else begin
              note_q <= note_q + NW'(1);
              last_q <= ((note_q + NW'(1)) == end_q);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign note_valid = valid_q;
  assign note       = note_q;
  assign note_last  = last_q;
  assign req_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_band_note_enumerator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_band_note_enumerator : self-checking bench for band_note_enumerator
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_band_note_enumerator;

  localparam int NB  = 22;
  localparam int MN  = 128;
  localparam int NPB = 6;
  localparam int NB4 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_band = '0;
  logic       note_valid;
  logic       note_ready = 1'b1;
  logic [6:0] note;
  logic       note_last;
  logic       req_err;

  logic       r4_valid = 1'b0;
  logic       r4_ready;
  logic [1:0] r4_band = '0;
  logic       n4_valid;
  logic       n4_ready = 1'b1;
  logic [6:0] n4_note;
  logic       n4_last;
  logic       e4_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int got[$];
  bit gotlast[$];
  int beat_cyc[$];
  int first_lat;
  int err_cnt;
  int err_cyc;
  bit valid_seen;
  bit stable_err;
  bit burst_done;

  always #5 clk = ~clk;

  band_note_enumerator #(
    .NUM_BANDS(NB), .MIDI_NOTES(MN), .NOTES_PER_BAND(NPB)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_band(req_band),
    .note_valid(note_valid), .note_ready(note_ready), .note(note),
    .note_last(note_last), .req_err(req_err)
  );

  band_note_enumerator #(
    .NUM_BANDS(NB4), .MIDI_NOTES(MN), .NOTES_PER_BAND(NPB)
  ) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(r4_valid), .req_ready(r4_ready), .req_band(r4_band),
    .note_valid(n4_valid), .note_ready(n4_ready), .note(n4_note),
    .note_last(n4_last), .req_err(e4_err)
  );

  // Reference: note range of a band straight from the partition rule.
  function automatic bit model_band(input int b, input int nb, output int s, output int e);
    s = b * NPB;
    e = 0;
    if (b >= nb || s >= MN) return 1'b1;
    e = (b == nb - 1) ? MN - 1 : s + NPB - 1;
    if (e > MN - 1) e = MN - 1;
    return 1'b0;
  endfunction

  function automatic int band_of(input int n, input int nb);
    return (n / NPB >= nb) ? nb - 1 : n / NPB;
  endfunction

  function automatic bit burst_matches(input int s, input int e);
    if (got.size() != e - s + 1) return 1'b0;
    foreach (got[i])
      if (got[i] != s + i || gotlast[i] != (i == e - s)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic ready_bit(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3 == 0);
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // Issues one request on the main DUT and records every accepted beat.
  task automatic run_burst(input int band, input int mode, input int maxcyc);
    bit         held = 1'b0;
    logic [6:0] hn = '0;
    logic       hl = 1'b0;
    int         k = 0;
    got.delete(); gotlast.delete(); beat_cyc.delete();
    first_lat = -1; err_cnt = 0; err_cyc = -1;
    valid_seen = 1'b0; stable_err = 1'b0; burst_done = 1'b0;
    req_band  = 5'(band);
    req_valid = 1'b1;
    for (int cyc = 1; cyc <= maxcyc && !burst_done; cyc++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_band  = 5'($urandom);
      if (req_err) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (note_valid) begin
        valid_seen = 1'b1;
        if (first_lat < 0) first_lat = cyc;
        if (held && (note !== hn || note_last !== hl)) stable_err = 1'b1;
        note_ready = ready_bit(mode, k);
        k++;
        if (note_ready) begin
          got.push_back(int'(note));
          gotlast.push_back(note_last);
          beat_cyc.push_back(cyc);
          held = 1'b0;
          if (note_last) burst_done = 1'b1;
        end else begin
          held = 1'b1; hn = note; hl = note_last;
        end
      end
    end
    if (burst_done) begin
      @(posedge clk); #1;
    end
    note_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else pass_cnt++;
    total_cnt++; if (note_valid !== 1'b0) $display("FAIL reset_note_valid: got %b want 0", note_valid); else pass_cnt++;
    total_cnt++; if (note !== 7'd0) $display("FAIL reset_note: got %0d want 0", note); else pass_cnt++;
    total_cnt++; if (note_last !== 1'b0) $display("FAIL reset_note_last: got %b want 0", note_last); else pass_cnt++;
    total_cnt++; if (req_err !== 1'b0) $display("FAIL reset_req_err: got %b want 0", req_err); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_band0();
    bit consecutive = 1'b1;
    run_burst(0, 0, 20);
    total_cnt++; if (!burst_done) $display("FAIL band0_done: got 0 want 1 (timeout)"); else pass_cnt++;
    total_cnt++; if (!burst_matches(0, 5)) $display("FAIL band0_seq: got %0d beats want notes 0..5 last on 5", got.size()); else pass_cnt++;
    foreach (beat_cyc[i]) if (beat_cyc[i] != i + 1) consecutive = 1'b0;
    total_cnt++; if (!consecutive || beat_cyc.size() != 6) $display("FAIL band0_rate: got %0d beats non-consecutive=%0b want 6 consecutive", beat_cyc.size(), !consecutive); else pass_cnt++;
    total_cnt++; if (first_lat != 1) $display("FAIL band0_latency: got %0d want 1", first_lat); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL band0_ready_after: got %b want 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_top_band();
    run_burst(21, 0, 20);
    total_cnt++; if (!burst_done || !burst_matches(126, 127)) $display("FAIL top_band_seq: got %0d beats done=%0b want 126,127", got.size(), burst_done); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1 || note_valid !== 1'b0) $display("FAIL top_band_idle: got ready=%b valid=%b want 1/0", req_ready, note_valid); else pass_cnt++;
  endtask

  task automatic test_reject();
    int bands[2] = '{22, 31};
    foreach (bands[j]) begin
      run_burst(bands[j], 0, 4);
      total_cnt++; if (err_cnt != 1 || err_cyc != 1) $display("FAIL reject_err_%0d: got pulses=%0d at=%0d want 1 at 1", bands[j], err_cnt, err_cyc); else pass_cnt++;
      total_cnt++; if (valid_seen || req_ready !== 1'b1) $display("FAIL reject_idle_%0d: got valid_seen=%0b ready=%b want 0/1", bands[j], valid_seen, req_ready); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    run_burst(3, 1, 60);
    total_cnt++; if (!burst_done || !burst_matches(18, 23)) $display("FAIL stall_seq: got %0d beats done=%0b want 18..23", got.size(), burst_done); else pass_cnt++;
    total_cnt++; if (stable_err) $display("FAIL stall_stable: got changing beat want held stable"); else pass_cnt++;
    total_cnt++; if (beat_cyc.size() != 6 || beat_cyc[5] != 16) $display("FAIL stall_timing: got %0d beats want 6 with last at cycle 16", beat_cyc.size()); else pass_cnt++;
  endtask

  task automatic test_narrow_build();
    int  s, e;
    int  ng[$];
    bit  nl[$];
    bit  done = 1'b0;
    bit  ok = 1'b1;
    void'(model_band(3, NB4, s, e));
    r4_band  = 2'd3;
    r4_valid = 1'b1;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(posedge clk); #1;
      r4_valid = 1'b0;
      if (n4_valid) begin
        n4_ready = 1'($urandom % 2);
        if (n4_ready) begin
          ng.push_back(int'(n4_note));
          nl.push_back(n4_last);
          if (n4_last) done = 1'b1;
        end
      end
    end
    n4_ready = 1'b1;
    if (ng.size() != e - s + 1) ok = 1'b0;
    foreach (ng[i]) if (ng[i] != s + i || nl[i] != (i == e - s)) ok = 1'b0;
    total_cnt++; if (!done || !ok) $display("FAIL narrow_seq: got %0d beats done=%0b want %0d..%0d", ng.size(), done, s, e); else pass_cnt++;
    total_cnt++; if (ng.size() != 110) $display("FAIL narrow_count: got %0d want 110", ng.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    req_band = 5'd10; req_valid = 1'b1; note_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++; if (note_valid !== 1'b1 || note !== 7'd62) $display("FAIL midrst_pre: got valid=%b note=%0d want 1/62", note_valid, note); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (note_valid !== 1'b0 || req_ready !== 1'b1 || note !== 7'd0) $display("FAIL midrst_async: got valid=%b ready=%b note=%0d want 0/1/0", note_valid, req_ready, note); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (note_valid !== 1'b0) $display("FAIL midrst_no_resume: got valid=%b want 0", note_valid); else pass_cnt++;
    run_burst(1, 0, 20);
    total_cnt++; if (!burst_done || !burst_matches(6, 11)) $display("FAIL midrst_next: got %0d beats done=%0b want 6..11", got.size(), burst_done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int   nts[$];
    int   cy[$];
    int   rb[$];
    bit   lst[$];
    int   hs = 0;
    logic pr;
    bit   seq_ok = 1'b1;
    bit   map_ok = 1'b1;
    req_band = 5'd5; req_valid = 1'b1; note_ready = 1'b1;
    pr = req_ready;
    for (int cyc = 1; cyc <= 40 && nts.size() < 12; cyc++) begin
      @(posedge clk); #1;
      if (pr && req_valid) begin
        hs++;
        if (hs == 1) req_band = 5'd6;
        else         req_valid = 1'b0;
      end
      pr = req_ready;
      if (note_valid) begin
        nts.push_back(int'(note));
        cy.push_back(cyc);
        lst.push_back(note_last);
        rb.push_back((hs == 1) ? 5 : 6);
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    if (nts.size() != 12) seq_ok = 1'b0;
    foreach (nts[i]) begin
      if (nts[i] != 30 + i || lst[i] != (i == 5 || i == 11)) seq_ok = 1'b0;
      if (band_of(nts[i], NB) != rb[i]) map_ok = 1'b0;
    end
    total_cnt++; if (!seq_ok) $display("FAIL b2b_seq: got %0d beats want 30..41 last on 35,41", nts.size()); else pass_cnt++;
    total_cnt++; if (!map_ok) $display("FAIL b2b_band_map: got note outside requested band want all mapped back"); else pass_cnt++;
    total_cnt++; if (cy.size() != 12 || cy[5] - cy[0] != 5 || cy[6] - cy[5] != 2) $display("FAIL b2b_bubble: got %0d beats want 6 consecutive then one bubble", cy.size()); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_idle: got ready=%b want 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_random();
    int b, s, e;
    bit er;
    for (int it = 0; it < 12; it++) begin
      b  = int'($urandom_range(0, 31));
      er = model_band(b, NB, s, e);
      run_burst(b, 2, er ? 4 : 200);
      if (er) begin
        total_cnt++; if (err_cnt != 1 || valid_seen) $display("FAIL rand_reject_%0d: got pulses=%0d valid_seen=%0b want 1/0", b, err_cnt, valid_seen); else pass_cnt++;
      end else begin
        total_cnt++; if (!burst_done || !burst_matches(s, e) || stable_err || err_cnt != 0) $display("FAIL rand_band_%0d: got %0d beats done=%0b unstable=%0b want %0d..%0d", b, got.size(), burst_done, stable_err, s, e); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_band0();
    test_top_band();
    test_reject();
    test_stall();
    test_narrow_build();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
